// File: rtl/core_pkg.sv
// Shared types and default widths for the single-cycle core sequencing logic.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Branch-target LUT index 0 is reserved and never names a valid target.
  localparam int BR_IDX_NONE = 0;

  localparam int PC_W   = 12;
  localparam int LUT_AW = 5;

endpackage

// File: rtl/pc_sequencer.sv
// PC register plus IDLE/RUN/DONE control; branch targets come from an external
// combinational LUT addressed by lut_addr, so pc updates one cycle after sampling.
module pc_sequencer
  import core_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int AW = LUT_AW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic [AW-1:0] lut_idx,
  output logic [AW-1:0] lut_addr,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  pc,
  output logic          running,
  output logic          done,
  output logic          bad_branch,
  output logic [CW-1:0] cycle_cnt
);

  seq_state_t    state_q;
  logic [D-1:0]  pc_q;
  logic          running_q;
  logic          done_q;
  logic          bad_q;
  logic [CW-1:0] cnt_q;

  logic          idx_reserved;

  assign lut_addr     = lut_idx;
  assign idx_reserved = (lut_idx == AW'(BR_IDX_NONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      bad_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= RUN;
            pc_q      <= start_addr;
            cnt_q     <= '0;
            bad_q     <= 1'b0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        RUN: begin
          // Counts every RUN cycle, including stalls and the halt cycle itself.
          if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
          if (stall) begin
            pc_q <= pc_q;
          end else if (halt) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (branch_en && branch_taken && !idx_reserved) begin
            pc_q <= lut_target;
          end else begin
            pc_q <= pc_q + D'(1);
            if (branch_en && branch_taken) bad_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign running    = running_q;
  assign done       = done_q;
  assign bad_branch = bad_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small fixed branch-target LUT.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] start_addr;
  logic        stall;
  logic        halt;
  logic        branch_en;
  logic        branch_taken;
  logic [4:0]  lut_idx;
  logic [4:0]  lut_addr;
  logic [11:0] lut_target;
  logic [11:0] pc;
  logic        running;
  logic        done;
  logic        bad_branch;
  logic [15:0] cycle_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .stall        (stall),
    .halt         (halt),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .lut_idx      (lut_idx),
    .lut_addr     (lut_addr),
    .lut_target   (lut_target),
    .pc           (pc),
    .running      (running),
    .done         (done),
    .bad_branch   (bad_branch),
    .cycle_cnt    (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External LUT: index 3 -> 48, index 7 -> 0x200, index 0 deliberately non-sequential.
  always_comb begin
    case (lut_addr)
      5'd0:    lut_target = 12'h7A0;
      5'd3:    lut_target = 12'd48;
      5'd7:    lut_target = 12'h200;
      default: lut_target = 12'h0AA;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; halt = 0; branch_en = 0; branch_taken = 0; lut_idx = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); start_addr = 12'h000; lut_idx = 5'd9;
    #3;
    total_cnt++;
    if ({pc, running, done, bad_branch, cycle_cnt} !== {12'h000, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      $display("FAIL reset_outputs pc=%h run=%b done=%b bad=%b cnt=%0d expected all zero", pc, running, done, bad_branch, cycle_cnt);
    end else pass_cnt++;
    total_cnt++;
    if (lut_addr !== 5'd9) $display("FAIL reset_lut_addr got %0d expected 9", lut_addr);
    else pass_cnt++;
    step(); step();
    rst_n = 1;
    step();
    total_cnt++;
    if (running !== 1'b0 || pc !== 12'h000) $display("FAIL idle_hold run=%b pc=%h expected 0/000", running, pc);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    idle_inputs(); start = 1; start_addr = 12'h005;
    step();
    start = 0;
    total_cnt++;
    if (pc !== 12'h005 || running !== 1'b1 || cycle_cnt !== 16'd0)
      $display("FAIL start_load pc=%h run=%b cnt=%0d expected 005/1/0", pc, running, cycle_cnt);
    else pass_cnt++;
    step(); step(); step();
    total_cnt++;
    if (pc !== 12'h008 || cycle_cnt !== 16'd3) $display("FAIL seq_3 pc=%h cnt=%0d expected 008/3", pc, cycle_cnt);
    else pass_cnt++;
    halt = 1;
    step();
    halt = 0;
    total_cnt++;
    if (done !== 1'b1 || running !== 1'b0 || pc !== 12'h008 || cycle_cnt !== 16'd4)
      $display("FAIL halt done=%b run=%b pc=%h cnt=%0d expected 1/0/008/4", done, running, pc, cycle_cnt);
    else pass_cnt++;
    branch_en = 1; branch_taken = 1; lut_idx = 5'd3;
    step(); step();
    idle_inputs();
    total_cnt++;
    if (done !== 1'b1 || pc !== 12'h008 || cycle_cnt !== 16'd4)
      $display("FAIL done_hold done=%b pc=%h cnt=%0d expected 1/008/4", done, pc, cycle_cnt);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    idle_inputs(); start = 1; start_addr = 12'h020;
    step();
    start = 0;
    total_cnt++;
    if (done !== 1'b0 || running !== 1'b1 || pc !== 12'h020)
      $display("FAIL restart_from_done done=%b run=%b pc=%h expected 0/1/020", done, running, pc);
    else pass_cnt++;
    branch_en = 1; branch_taken = 1; lut_idx = 5'd3;
    step();
    total_cnt++;
    if (pc !== 12'h030) $display("FAIL branch_taken pc=%h expected 030", pc);
    else pass_cnt++;
    branch_taken = 0;
    step();
    total_cnt++;
    if (pc !== 12'h031) $display("FAIL branch_not_taken pc=%h expected 031", pc);
    else pass_cnt++;
    idle_inputs(); start = 1; start_addr = 12'h100;
    step();
    start = 0;
    total_cnt++;
    if (pc !== 12'h032 || running !== 1'b1 || cycle_cnt !== 16'd3)
      $display("FAIL start_in_run pc=%h run=%b cnt=%0d expected 032/1/3", pc, running, cycle_cnt);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    stall = 1; halt = 1; branch_en = 1; branch_taken = 1; lut_idx = 5'd7;
    step(); step();
    total_cnt++;
    if (pc !== 12'h032 || running !== 1'b1 || done !== 1'b0 || cycle_cnt !== 16'd5)
      $display("FAIL stall_hold pc=%h run=%b done=%b cnt=%0d expected 032/1/0/5", pc, running, done, cycle_cnt);
    else pass_cnt++;
    stall = 0;
    step();
    idle_inputs();
    total_cnt++;
    if (done !== 1'b1 || running !== 1'b0 || pc !== 12'h032 || cycle_cnt !== 16'd6)
      $display("FAIL stall_release_halt done=%b run=%b pc=%h cnt=%0d expected 1/0/032/6", done, running, pc, cycle_cnt);
    else pass_cnt++;
  endtask

  task automatic test_bad_branch();
    idle_inputs(); start = 1; start_addr = 12'h010;
    step();
    start = 0; branch_en = 1; branch_taken = 1; lut_idx = 5'd0;
    step();
    idle_inputs();
    total_cnt++;
    if (pc !== 12'h011 || bad_branch !== 1'b1) $display("FAIL bad_branch_set pc=%h bad=%b expected 011/1", pc, bad_branch);
    else pass_cnt++;
    halt = 1;
    step();
    halt = 0;
    step();
    total_cnt++;
    if (done !== 1'b1 || bad_branch !== 1'b1) $display("FAIL bad_branch_sticky done=%b bad=%b expected 1/1", done, bad_branch);
    else pass_cnt++;
    start = 1; start_addr = 12'hFFE;
    step();
    start = 0;
    total_cnt++;
    if (bad_branch !== 1'b0 || pc !== 12'hFFE || running !== 1'b1)
      $display("FAIL bad_branch_clear bad=%b pc=%h run=%b expected 0/FFE/1", bad_branch, pc, running);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    step();
    total_cnt++;
    if (pc !== 12'hFFF) $display("FAIL wrap_1 pc=%h expected FFF", pc);
    else pass_cnt++;
    step();
    total_cnt++;
    if (pc !== 12'h000 || bad_branch !== 1'b0 || cycle_cnt !== 16'd2)
      $display("FAIL wrap_2 pc=%h bad=%b cnt=%0d expected 000/0/2", pc, bad_branch, cycle_cnt);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 0;
    #1;
    total_cnt++;
    if ({pc, running, done, bad_branch, cycle_cnt} !== {12'h000, 1'b0, 1'b0, 1'b0, 16'd0})
      $display("FAIL async_reset pc=%h run=%b done=%b bad=%b cnt=%0d expected all zero", pc, running, done, bad_branch, cycle_cnt);
    else pass_cnt++;
    step();
    rst_n = 1;
    step();
    total_cnt++;
    if (running !== 1'b0 || done !== 1'b0 || pc !== 12'h000)
      $display("FAIL post_reset_idle run=%b done=%b pc=%h expected 0/0/000", running, done, pc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_bad_branch();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
